// File: rtl/soup_if.sv
// soup_if: engine-side soup handshake bundle.
//
// Handshake: the scheduler raises soup_valid with soup_dst one-hot and holds
// soup_dst/soup_data/soup_seq stable until a rising clock edge at which
// ack[dst] is high; that edge is the transfer. ack bits of other engines,
// and any ack while soup_valid is low, have no effect. req is a level
// request per engine and may drop at any time without aborting a soup
// already on the bus.
//
// Signals
//   req        engines -> sched  NENG  per-engine soup request (level)
//   ack        engines -> sched  NENG  per-engine accept
//   soup_valid sched -> engines  1     soup bus valid
//   soup_dst   sched -> engines  NENG  one-hot destination, 0 when idle
//   soup_data  sched -> engines  NI    captured soup
//   soup_seq   sched -> engines  SEQW  sequence number of the soup
interface soup_if #(
  parameter int NI   = 400,
  parameter int NENG = 4,
  parameter int SEQW = 32
) ();
  logic [NENG-1:0] req;
  logic [NENG-1:0] ack;
  logic            soup_valid;
  logic [NENG-1:0] soup_dst;
  logic [NI-1:0]   soup_data;
  logic [SEQW-1:0] soup_seq;

  modport master (
    input  req, ack,
    output soup_valid, soup_dst, soup_data, soup_seq
  );

  modport slave (
    output req, ack,
    input  soup_valid, soup_dst, soup_data, soup_seq
  );
endinterface

// File: rtl/soup_sched.sv
// soup_sched: hands random soups from the RNG to NENG Life engines.
//
// After reset the RNG is held in reset for one extra cycle and its output is
// discarded for WARMUP cycles. Afterwards one soup at a time is captured from
// rng_x_i and offered to the round-robin winner among requesting engines.
// The RNG density config is either fixed (cfg_mode_i) or swept 0..3, moving
// on every SWEEP_N delivered soups. A gap counter keeps at least MIN_GAP
// idle cycles after every delivery and after every config change so the RNG
// output reflects the current config before the next capture.
//
// Ports
//   clk          clock
//   reset        synchronous, active-high
//   enable_i     0: finish in-flight soup, grant nothing new
//   sweep_en_i   1: sweep density configs, 0: use cfg_mode_i
//   cfg_mode_i   fixed density config
//   rng_cfg_o    RNG config input
//   rng_reset_o  RNG reset input
//   rng_x_i      RNG output word
//   sif          soup handshake (master side)
//   soups_out_o  soups delivered since reset (wraps)
//   dbg_state_o  FSM state: 0 WARM, 1 IDLE, 2 BUSY
module soup_sched #(
  parameter int NI      = 400,
  parameter int NENG    = 4,
  parameter int SEQW    = 32,
  parameter int WARMUP  = 64,
  parameter int MIN_GAP = 4,
  parameter int SWEEP_N = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable_i,
  input  logic            sweep_en_i,
  input  logic [1:0]      cfg_mode_i,
  output logic [1:0]      rng_cfg_o,
  output logic            rng_reset_o,
  input  logic [NI-1:0]   rng_x_i,
  soup_if.master          sif,
  output logic [SEQW-1:0] soups_out_o,
  output logic [1:0]      dbg_state_o
);

  localparam int PTRW = (NENG > 1) ? $clog2(NENG) : 1;
  localparam int WCW  = $clog2(WARMUP + 1);
  localparam int GW   = $clog2(MIN_GAP + 1);
  localparam int SCW  = (SWEEP_N > 1) ? $clog2(SWEEP_N) : 1;

  typedef enum logic [1:0] {
    ST_WARM = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [WCW-1:0]  warm_q, warm_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [PTRW-1:0] ptr_q, ptr_d;
  logic [1:0]      sidx_q, sidx_d;
  logic [SCW-1:0]  scnt_q, scnt_d;
  logic [1:0]      cfg_prev_q, cfg_prev_d;
  logic            rst_q;
  logic            valid_q, valid_d;
  logic [NENG-1:0] dst_q, dst_d;
  logic [NI-1:0]   data_q, data_d;
  logic [SEQW-1:0] seq_q, seq_d;
  logic [SEQW-1:0] outs_q, outs_d;

  logic            found;
  logic [PTRW-1:0] win;
  logic            cfg_chg;
  logic            acked;

  assign rng_cfg_o      = sweep_en_i ? sidx_q : cfg_mode_i;
  // Covers every reset cycle combinationally plus the cycle right after.
  assign rng_reset_o    = reset | rst_q;
  assign sif.soup_valid = valid_q;
  assign sif.soup_dst   = dst_q;
  assign sif.soup_data  = data_q;
  assign sif.soup_seq   = seq_q;
  assign soups_out_o    = outs_q;
  assign dbg_state_o    = state_q;

  // cfg_prev_q holds what rng_cfg_o would be this cycle if the inputs had not
  // moved, so sweep steps taken at the ack edge are not seen as a change
  // (the ack already reloaded the gap).
  assign cfg_chg = (rng_cfg_o != cfg_prev_q);
  assign acked   = |(sif.ack & dst_q);

  // Round-robin search: first requester at or after ptr_q, wrapping.
  always_comb begin
    int j;
    found = 1'b0;
    win   = '0;
    j     = 0;
    for (int k = 0; k < NENG; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NENG) j = j - NENG;
      if (!found && sif.req[j]) begin
        found = 1'b1;
        win   = PTRW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    sidx_d  = sidx_q;
    scnt_d  = scnt_q;
    valid_d = valid_q;
    dst_d   = dst_q;
    data_d  = data_q;
    seq_d   = seq_q;
    outs_d  = outs_q;

    case (state_q)
      ST_WARM: begin
        if (warm_q <= WCW'(1)) begin
          warm_d  = '0;
          state_d = ST_IDLE;
        end else begin
          warm_d = warm_q - WCW'(1);
        end
      end
      ST_IDLE: begin
        if (cfg_chg) begin
          gap_d = GW'(MIN_GAP);
        end else if (gap_q != '0) begin
          gap_d = gap_q - GW'(1);
        end else if (enable_i && found) begin
          data_d  = rng_x_i;
          dst_d   = NENG'(1) << win;
          valid_d = 1'b1;
          seq_d   = outs_q;
          ptr_d   = (int'(win) == NENG - 1) ? '0 : win + PTRW'(1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (acked) begin
          valid_d = 1'b0;
          dst_d   = '0;
          outs_d  = outs_q + SEQW'(1);
          gap_d   = GW'(MIN_GAP);
          state_d = ST_IDLE;
          if (sweep_en_i) begin
            if (int'(scnt_q) == SWEEP_N - 1) begin
              scnt_d = '0;
              sidx_d = sidx_q + 2'd1;
            end else begin
              scnt_d = scnt_q + SCW'(1);
            end
          end
        end
      end
      default: state_d = ST_WARM;
    endcase

    cfg_prev_d = sweep_en_i ? sidx_d : cfg_mode_i;
  end

  always_ff @(posedge clk) begin
    rst_q <= reset;
    if (reset) begin
      state_q    <= ST_WARM;
      warm_q     <= WCW'(WARMUP);
      gap_q      <= '0;
      ptr_q      <= '0;
      sidx_q     <= '0;
      scnt_q     <= '0;
      cfg_prev_q <= sweep_en_i ? 2'd0 : cfg_mode_i;
      valid_q    <= 1'b0;
      dst_q      <= '0;
      data_q     <= '0;
      seq_q      <= '0;
      outs_q     <= '0;
    end else begin
      state_q    <= state_d;
      warm_q     <= warm_d;
      gap_q      <= gap_d;
      ptr_q      <= ptr_d;
      sidx_q     <= sidx_d;
      scnt_q     <= scnt_d;
      cfg_prev_q <= cfg_prev_d;
      valid_q    <= valid_d;
      dst_q      <= dst_d;
      data_q     <= data_d;
      seq_q      <= seq_d;
      outs_q     <= outs_d;
    end
  end

endmodule

// File: tb/tb_soup_sched.sv
// tb_soup_sched: directed bench for soup_sched with small parameters
// (NI=16, NENG=4, SEQW=4, WARMUP=8, MIN_GAP=4, SWEEP_N=2).
module tb_soup_sched;

  localparam int NI      = 16;
  localparam int NENG    = 4;
  localparam int SEQW    = 4;
  localparam int WARMUP  = 8;
  localparam int MIN_GAP = 4;
  localparam int SWEEP_N = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic            enable;
  logic            sweep_en;
  logic [1:0]      cfg_mode;
  logic [1:0]      rng_cfg;
  logic            rng_reset;
  logic [NI-1:0]   rng_x;
  logic [SEQW-1:0] soups_out;
  logic [1:0]      dbg_state;

  soup_if #(.NI(NI), .NENG(NENG), .SEQW(SEQW)) sif ();

  soup_sched #(
    .NI(NI), .NENG(NENG), .SEQW(SEQW),
    .WARMUP(WARMUP), .MIN_GAP(MIN_GAP), .SWEEP_N(SWEEP_N)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable_i    (enable),
    .sweep_en_i  (sweep_en),
    .cfg_mode_i  (cfg_mode),
    .rng_cfg_o   (rng_cfg),
    .rng_reset_o (rng_reset),
    .rng_x_i     (rng_x),
    .sif         (sif.master),
    .soups_out_o (soups_out),
    .dbg_state_o (dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [NENG-1:0] exp_q[$];
  int cyc = 0;
  logic [NI-1:0] x_prev;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the edge. x_prev keeps the rng word seen at the edge just taken.
  task automatic tick();
    logic [7:0] c8;
    x_prev = rng_x;
    @(posedge clk);
    #1;
    cyc++;
    c8    = cyc[7:0];
    rng_x = {c8, ~c8};
  endtask

  task automatic wait_valid(input string tag, input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sif.soup_valid && n < max);
    if (!sif.soup_valid) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_rng_reset_in", rng_reset, 1);
    tick();
    tick();
    check("rst_valid", sif.soup_valid, 0);
    check("rst_dst", sif.soup_dst, 0);
    check("rst_data", sif.soup_data, 0);
    check("rst_seq", sif.soup_seq, 0);
    check("rst_soups_out", soups_out, 0);
    check("rst_state", dbg_state, 0);
    check("rst_cfg", rng_cfg, sweep_en ? 2'd0 : cfg_mode);
    reset = 1'b0;
    #1;
    check("rst_rng_reset_after", rng_reset, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [NI-1:0] hold_data;
    int cfg_tab[9];
    cfg_tab = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

    reset    = 1'b1;
    enable   = 1'b1;
    sweep_en = 1'b0;
    cfg_mode = 2'd1;
    rng_x    = '0;
    sif.req  = 4'b1111;
    sif.ack  = 4'b1111;

    // 1: warm-up hold-off, then strict round robin
    do_reset();
    check("t1_cfg_fixed", rng_cfg, 1);
    wait_valid("t1_first", 100, n);
    check("t1_warm_latency", n, WARMUP + 1);
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        wait_valid("t1_next", 40, n);
        check("t1_spacing", n, 2 + MIN_GAP);
      end
      check("t1_dst", sif.soup_dst, exp_q.pop_front());
      check("t1_seq", sif.soup_seq, k);
      check("t1_data", sif.soup_data, x_prev);
      check("t1_rng_reset_low", rng_reset, 0);
      if (k == 4) sif.req = '0;
    end
    tick();
    check("t1_soups_out", soups_out, 5);
    check("t1_valid_drop", sif.soup_valid, 0);

    // 2: held outputs during a long BUSY, gap after ack
    sif.req = 4'b0100;
    sif.ack = '0;
    wait_valid("t2_a", 40, n);
    check("t2_gap_after_ack", n, MIN_GAP + 1);
    hold_data = x_prev;
    check("t2_dst", sif.soup_dst, 4'b0100);
    check("t2_seq", sif.soup_seq, 5);
    check("t2_state_busy", dbg_state, 2);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t2_hold_valid", sif.soup_valid, 1);
      check("t2_hold_dst", sif.soup_dst, 4'b0100);
      check("t2_hold_seq", sif.soup_seq, 5);
      check("t2_hold_data", sif.soup_data, hold_data);
    end
    sif.ack = 4'b0100;
    tick();
    sif.ack = '0;
    check("t2_ack_valid", sif.soup_valid, 0);
    check("t2_ack_dst", sif.soup_dst, 0);
    check("t2_ack_count", soups_out, 6);
    wait_valid("t2_b", 40, n);
    check("t2_next_capture", n, MIN_GAP + 1);
    check("t2_seq2", sif.soup_seq, 6);
    sif.ack = 4'b0100;
    tick();
    sif.req = '0;
    sif.ack = '0;
    check("t2_count2", soups_out, 7);

    // 4: stray acks and dropped req do not disturb the soup
    sif.req = 4'b0010;
    wait_valid("t4", 40, n);
    check("t4_dst", sif.soup_dst, 4'b0010);
    check("t4_seq", sif.soup_seq, 7);
    sif.ack = 4'b1101;
    tick();
    check("t4_wrong_ack_valid", sif.soup_valid, 1);
    check("t4_wrong_ack_count", soups_out, 7);
    sif.ack = '0;
    sif.req = '0;
    tick();
    check("t4_req_drop_valid", sif.soup_valid, 1);
    check("t4_req_drop_dst", sif.soup_dst, 4'b0010);
    sif.ack = 4'b0010;
    tick();
    check("t4_deliver_valid", sif.soup_valid, 0);
    check("t4_deliver_count", soups_out, 8);
    sif.ack = 4'b1111;
    for (int k = 0; k < 3; k++) tick();
    check("t4_idle_ack_count", soups_out, 8);
    check("t4_idle_ack_valid", sif.soup_valid, 0);
    sif.ack = '0;

    // 3: density sweep, then a fixed-config change that reloads the gap
    sweep_en = 1'b1;
    sif.req  = 4'b0001;
    sif.ack  = 4'b0001;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      wait_valid("t3", 40, n);
      check("t3_cfg", rng_cfg, cfg_tab[k]);
      if (k == 8) begin
        check("t3_soups_out8", soups_out, 8);
        sif.req = '0;
      end
    end
    tick();
    check("t3_soups_out9", soups_out, 9);
    sweep_en = 1'b0;
    cfg_mode = 2'd2;
    #1;
    check("t3_cfg_fixed", rng_cfg, 2);
    for (int k = 0; k < 10; k++) tick();
    cfg_mode = 2'd3;
    sif.req  = 4'b0001;
    wait_valid("t3_reload", 40, n);
    check("t3_cfg_gap_reload", n, MIN_GAP + 2);
    check("t3_cfg_new", rng_cfg, 3);
    sif.ack = '0;

    // 5: reset in the middle of BUSY
    tick();
    check("t5_busy", sif.soup_valid, 1);
    reset = 1'b1;
    tick();
    check("t5_valid", sif.soup_valid, 0);
    check("t5_dst", sif.soup_dst, 0);
    check("t5_count", soups_out, 0);
    check("t5_rng_reset", rng_reset, 1);
    check("t5_state", dbg_state, 0);
    reset = 1'b0;
    #1;
    check("t5_rng_reset_after", rng_reset, 1);
    wait_valid("t5_rewarm", 100, n);
    check("t5_warm_latency", n, WARMUP + 1);
    check("t5_seq", sif.soup_seq, 0);
    check("t5_rng_reset_low", rng_reset, 0);
    sif.ack = 4'b0001;
    sif.req = '0;
    tick();
    sif.ack = '0;

    // 6: sequence wrap and enable=0 mid-BUSY
    sif.req = 4'b1111;
    sif.ack = 4'b1111;
    do_reset();
    for (int k = 0; k < 17; k++) begin
      wait_valid("t6", 100, n);
      check("t6_seq", sif.soup_seq, k % 16);
      check("t6_dst", sif.soup_dst, 4'b0001 << (k % 4));
    end
    sif.ack = '0;
    enable  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t6_dis_hold", sif.soup_valid, 1);
      check("t6_dis_seq", sif.soup_seq, 0);
    end
    sif.ack = 4'b1111;
    tick();
    check("t6_dis_done", sif.soup_valid, 0);
    check("t6_count_wrap", soups_out, 1);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (sif.soup_valid) n++;
    end
    check("t6_no_grant", n, 0);
    enable = 1'b1;
    wait_valid("t6_resume", 10, n);
    check("t6_resume_lat", n, 1);
    check("t6_resume_dst", sif.soup_dst, 4'b0010);
    check("t6_resume_seq", sif.soup_seq, 1);
    tick();

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
